sr_ff_bank: RTL and testbench

- Clocked, multi-channel successor to the team's single SR latch.
- N independent SR storage channels, updated on the rising clock edge. The forbidden S=R=1 input is resolved by a runtime-selectable mode instead of producing an undefined state.
- Per-channel sticky conflict flags and a global saturating conflict counter, for debug/status readout by the lab top level.

---
 rtl/sr_ff_pkg.sv | 24 ++
 rtl/sr_ff_cell.sv | 61 ++++++
 rtl/sr_ff_bank.sv | 60 ++++++
 tb/tb_sr_ff_bank.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// Shared definitions for the clocked SR flip-flop bank: conflict
// resolution modes and the conflict-counter saturation helper.
package sr_ff_pkg;

    // S=R=1 resolution modes; the encoding matches the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SET  = 2'b01,
        MODE_RST  = 2'b10,
        MODE_TGL  = 2'b11
    } sr_mode_e;

    // All-ones value of a w-bit counter, i.e. the saturation point.
    // Results are valid for widths up to 32 bits.
    function automatic logic [31:0] cnt_max(input int unsigned w);
        logic [31:0] v;
        v = '1;
        if (w < 32) begin
            v = (32'd1 << w) - 32'd1;
        end
        return v;
    endfunction

endpackage : sr_ff_pkg

// File: rtl/sr_ff_cell.sv
// One SR storage channel with mode-resolved S=R=1 handling and a sticky
// conflict flag. All state changes on the rising edge of clk.
module sr_ff_cell
    import sr_ff_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       s,
    input  logic       r,
    input  logic [1:0] mode,
    input  logic       clr_err,
    output logic       q,
    output logic       q_bar,
    output logic       conflict
);

    logic r_q;
    logic r_conflict;
    logic w_q_next;
    logic w_conflict_now;

    assign w_conflict_now = s & r;

    // Next-state selection: plain SR behaviour, with S=R=1 resolved by mode.
    always_comb begin
        w_q_next = r_q;
        unique case ({s, r})
            2'b00: w_q_next = r_q;
            2'b10: w_q_next = 1'b1;
            2'b01: w_q_next = 1'b0;
            2'b11: begin
                unique case (mode)
                    MODE_HOLD: w_q_next = r_q;
                    MODE_SET:  w_q_next = 1'b1;
                    MODE_RST:  w_q_next = 1'b0;
                    MODE_TGL:  w_q_next = ~r_q;
                    default:   w_q_next = r_q;
                endcase
            end
            default: w_q_next = r_q;
        endcase
    end

    // Channel state and sticky flag; a conflict on the clearing edge wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q        <= init;
            r_conflict <= 1'b0;
        end else begin
            r_q        <= w_q_next;
            r_conflict <= w_conflict_now | (r_conflict & ~clr_err);
        end
    end

    // q_bar derives from the same register, so it is never equal to q.
    assign q        = r_q;
    assign q_bar    = ~r_q;
    assign conflict = r_conflict;

endmodule : sr_ff_cell

// File: rtl/sr_ff_bank.sv
// N-channel clocked SR flip-flop bank with runtime-selectable S=R=1
// resolution, per-channel sticky conflict flags and a global saturating
// conflict-cycle counter for status readout.
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int unsigned     N     = 4,
    parameter logic [N-1:0]    INIT  = {N{1'b0}},
    parameter int unsigned     CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic [1:0]       mode,
    input  logic             clr_err,
    output logic [N-1:0]     q,
    output logic [N-1:0]     q_bar,
    output logic [N-1:0]     conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_any_conflict;

    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        sr_ff_cell u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .init     (INIT[gi]),
            .s        (s[gi]),
            .r        (r[gi]),
            .mode     (mode),
            .clr_err  (clr_err),
            .q        (q[gi]),
            .q_bar    (q_bar[gi]),
            .conflict (conflict[gi])
        );
    end

    // One count per cycle, however many channels conflict in it.
    assign w_any_conflict = |(s & r);

    // Saturating conflict counter; a clear coinciding with a conflict loads 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_err) begin
            r_cnt <= w_any_conflict ? CNT_ONE : '0;
        end else if (w_any_conflict && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign conflict_cnt = r_cnt;

endmodule : sr_ff_bank

// File: tb/tb_sr_ff_bank.sv
// Directed self-checking bench for sr_ff_bank (N=4, INIT=0, CNT_W=3).
module tb_sr_ff_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] s;
    logic [3:0] r;
    logic [1:0] mode;
    logic       clr_err;
    logic [3:0] q;
    logic [3:0] q_bar;
    logic [3:0] conflict;
    logic [2:0] conflict_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    sr_ff_bank #(
        .N     (4),
        .INIT  (4'b0000),
        .CNT_W (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s            (s),
        .r            (r),
        .mode         (mode),
        .clr_err      (clr_err),
        .q            (q),
        .q_bar        (q_bar),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] eq,
                             input logic [3:0] econf, input logic [2:0] ecnt);
        chk({tag, ".q"},     {28'd0, q},            {28'd0, eq});
        chk({tag, ".q_bar"}, {28'd0, q_bar},        {28'd0, ~eq});
        chk({tag, ".conf"},  {28'd0, conflict},     {28'd0, econf});
        chk({tag, ".cnt"},   {29'd0, conflict_cnt}, {29'd0, ecnt});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; s = '0; r = '0; mode = 2'b00; clr_err = 1'b0;

        // Reset
        step(); step();
        chk_state("reset", 4'b0000, 4'b0000, 3'd0);

        // Basic set / reset
        rst_n = 1'b1; s = 4'b0101; r = 4'b0000;
        step();
        chk_state("set", 4'b0101, 4'b0000, 3'd0);
        s = 4'b0000; r = 4'b0001;
        step();
        chk_state("rst", 4'b0100, 4'b0000, 3'd0);

        // Mode sweep on channel 0
        s = 4'b0001; r = 4'b0000;
        step();
        chk_state("restore0", 4'b0101, 4'b0000, 3'd0);
        s = 4'b0001; r = 4'b0001; mode = 2'b00;
        step();
        chk_state("m_hold", 4'b0101, 4'b0001, 3'd1);
        mode = 2'b01;
        step();
        chk_state("m_set", 4'b0101, 4'b0001, 3'd2);
        mode = 2'b10;
        step();
        chk_state("m_rst", 4'b0100, 4'b0001, 3'd3);
        s = 4'b0001; r = 4'b0000;
        step();
        chk_state("restore1", 4'b0101, 4'b0001, 3'd3);
        s = 4'b0001; r = 4'b0001; mode = 2'b11;
        step();
        chk_state("m_tgl1", 4'b0100, 4'b0001, 3'd4);
        step();
        chk_state("m_tgl0", 4'b0101, 4'b0001, 3'd5);

        // Plain clear
        s = '0; r = '0; mode = 2'b00; clr_err = 1'b1;
        step();
        chk_state("clr", 4'b0101, 4'b0000, 3'd0);
        clr_err = 1'b0;

        // Counter saturation
        s = 4'b1111; r = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_state($sformatf("sat%0d", k), 4'b0101, 4'b1111,
                      (k < 7) ? 3'(k) : 3'd7);
        end

        // Clear collision
        s = '0; r = '0; clr_err = 1'b1;
        step();
        chk_state("pre_clr", 4'b0101, 4'b0000, 3'd0);
        clr_err = 1'b0; s = 4'b0011; r = 4'b0011;
        step(); step(); step(); step(); step();
        chk_state("cnt5", 4'b0101, 4'b0011, 3'd5);
        clr_err = 1'b1; s = 4'b0010; r = 4'b0010;
        step();
        chk_state("clr_coll", 4'b0101, 4'b0010, 3'd1);
        s = '0; r = '0;
        step();
        chk_state("clr_only", 4'b0101, 4'b0000, 3'd0);
        clr_err = 1'b0;

        // Mid-operation reset
        s = 4'b1111; r = 4'b0000;
        step();
        chk_state("all_set", 4'b1111, 4'b0000, 3'd0);
        s = 4'b0001; r = 4'b0001;
        step(); step(); step();
        chk_state("cnt3", 4'b1111, 4'b0001, 3'd3);
        rst_n = 1'b0; s = 4'b1111; r = 4'b0000;
        step();
        chk_state("mid_rst", 4'b0000, 4'b0000, 3'd0);
        rst_n = 1'b1;
        step();
        chk_state("post_rst", 4'b1111, 4'b0000, 3'd0);

        // Activity then hold
        s = 4'b1010; r = 4'b0101;
        step();
        chk_state("act1", 4'b1010, 4'b0000, 3'd0);
        s = 4'b0011; r = 4'b0011; mode = 2'b11;
        step();
        chk_state("act2", 4'b1001, 4'b0011, 3'd1);
        s = '0; r = '0; mode = 2'b00;
        for (int k = 0; k < 20; k++) begin
            step();
            chk({"hold.q"}, {28'd0, q}, {28'd0, 4'b1001});
        end
        chk_state("hold_end", 4'b1001, 4'b0011, 3'd1);

        // Input wiggles between edges must not reach the outputs
        #1 s = 4'b1111;
        #1 chk_state("glitch1", 4'b1001, 4'b0011, 3'd1);
        r = 4'b1111; mode = 2'b10; clr_err = 1'b1;
        #1 chk_state("glitch2", 4'b1001, 4'b0011, 3'd1);
        s = 4'b0100; r = 4'b0001; mode = 2'b00; clr_err = 1'b0;
        #1 chk_state("glitch3", 4'b1001, 4'b0011, 3'd1);
        step();
        chk_state("after_glitch", 4'b1100, 4'b0011, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sr_ff_bank
